// File: rtl/tb_dina_map_pipe_if.sv
// ---------------------------------------------------------------------------
// tb_dina_map_pipe_if
//   Bundles the source-side and sink-side handshakes of the temp-buffer
//   port-A write-data mapper.
//   master : the producer/consumer environment (drives beats, takes results)
//   slave  : the mapper itself
// Signals
//   in_valid/in_ready   input beat handshake
//   src_sel, dir        source index and mapping mode (00 IDLE 01 POS 10 NEG 11 NEW)
//   slot_ld, slot_in    explicit slot reload for NEW beats
//   src_data            N_SRC concatenated L-lane sources
//   out_valid/out_ready FIFO head handshake
//   TB_dina, TB_lane_en mapped head data and per-lane write enable
//   sel_err             sticky out-of-range source flag
// ---------------------------------------------------------------------------
interface tb_dina_map_pipe_if #(
    parameter int L          = 4,
    parameter int RSA_DW     = 32,
    parameter int N_SRC      = 2,
    parameter int SRC_SEL_DW = 1,
    parameter int SLOT_DW    = 1
);
    logic                        in_valid;
    logic                        in_ready;
    logic [SRC_SEL_DW-1:0]       src_sel;
    logic [1:0]                  dir;
    logic                        slot_ld;
    logic [SLOT_DW-1:0]          slot_in;
    logic [N_SRC*L*RSA_DW-1:0]   src_data;
    logic                        out_valid;
    logic                        out_ready;
    logic [L*RSA_DW-1:0]         TB_dina;
    logic [L-1:0]                TB_lane_en;
    logic                        sel_err;

    modport master (
        output in_valid, src_sel, dir, slot_ld, slot_in, src_data, out_ready,
        input  in_ready, out_valid, TB_dina, TB_lane_en, sel_err
    );

    modport slave (
        input  in_valid, src_sel, dir, slot_ld, slot_in, src_data, out_ready,
        output in_ready, out_valid, TB_dina, TB_lane_en, sel_err
    );
endinterface

// File: rtl/tb_dina_map_pipe.sv
// ---------------------------------------------------------------------------
// tb_dina_map_pipe
//   Flow-controlled temp-buffer port-A write-data mapper. Selects one of N_SRC
//   L-lane sources, remaps the lanes (POS straight, NEG reversed, NEW packed
//   into a NEW_W-lane landmark slot) and queues the result in a 2-entry FIFO
//   whose head drives the TB port-A write path with a per-lane write mask.
// Ports
//   clk      clock
//   sys_rst  synchronous active-high reset
//   bus      tb_dina_map_pipe_if.slave (beat in, mapped beat out, sel_err)
// ---------------------------------------------------------------------------
module tb_dina_map_pipe #(
    parameter int L          = 4,
    parameter int RSA_DW     = 32,
    parameter int N_SRC      = 2,
    parameter int SRC_SEL_DW = 1,
    parameter int NEW_W      = 2,
    parameter int SLOT_DW    = 1
) (
    input  logic                clk,
    input  logic                sys_rst,
    tb_dina_map_pipe_if.slave   bus
);
    localparam int LW    = L * RSA_DW;
    localparam int GW    = NEW_W * RSA_DW;
    localparam int NSLOT = L / NEW_W;

    // FIFO: entry 0 is always the head; entry 1 shifts down on a pop.
    logic [1:0]          r_cnt;
    logic [LW-1:0]       r_dat0;
    logic [LW-1:0]       r_dat1;
    logic [L-1:0]        r_en0;
    logic [L-1:0]        r_en1;
    logic [SLOT_DW-1:0]  r_slot_ptr;
    logic                r_sel_err;

    logic                w_push;
    logic                w_pop;
    logic [LW-1:0]       w_src;
    logic                w_sel_bad;
    logic [LW-1:0]       w_map_dat;
    logic [L-1:0]        w_map_en;
    logic [SLOT_DW-1:0]  w_slot;
    logic [SLOT_DW-1:0]  w_slot_nxt;

    // Ready depends only on the registered count, so out_ready never reaches in_ready.
    assign bus.in_ready   = (r_cnt != 2'd2);
    assign bus.out_valid  = (r_cnt != 2'd0);
    assign bus.TB_dina    = bus.out_valid ? r_dat0 : '0;
    assign bus.TB_lane_en = bus.out_valid ? r_en0  : '0;
    assign bus.sel_err    = r_sel_err;

    assign w_push = bus.in_valid & bus.in_ready;
    assign w_pop  = bus.out_valid & bus.out_ready;

    // Source select; an index with no matching source leaves w_sel_bad set.
    always_comb begin
        w_src     = '0;
        w_sel_bad = 1'b1;
        for (int s = 0; s < N_SRC; s++) begin
            if (32'(bus.src_sel) == 32'(s)) begin
                w_src     = bus.src_data[s*LW +: LW];
                w_sel_bad = 1'b0;
            end
        end
    end

    // Lane remap of the accepted beat.
    always_comb begin
        w_map_dat = '0;
        w_map_en  = '0;
        w_slot    = bus.slot_ld ? bus.slot_in : r_slot_ptr;
        if (!w_sel_bad) begin
            case (bus.dir)
                2'b01: begin
                    w_map_dat = w_src;
                    w_map_en  = '1;
                end
                2'b10: begin
                    for (int i = 0; i < L; i++) begin
                        w_map_dat[i*RSA_DW +: RSA_DW] = w_src[(L-1-i)*RSA_DW +: RSA_DW];
                    end
                    w_map_en = '1;
                end
                2'b11: begin
                    // Only the low NEW_W source lanes form a landmark group.
                    for (int k = 0; k < NSLOT; k++) begin
                        if (32'(w_slot) == 32'(k)) begin
                            w_map_dat[k*GW +: GW]       = w_src[GW-1:0];
                            w_map_en[k*NEW_W +: NEW_W]  = '1;
                        end
                    end
                end
                default: begin
                    // IDLE: bubble write, zero data and mask
                end
            endcase
        end
    end

    // Wrap after the last slot; an out-of-range explicit slot also wraps to 0.
    always_comb begin
        if (32'(w_slot) >= 32'(NSLOT - 1)) begin
            w_slot_nxt = '0;
        end else begin
            w_slot_nxt = w_slot + SLOT_DW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (sys_rst) begin
            r_cnt      <= 2'd0;
            r_dat0     <= '0;
            r_dat1     <= '0;
            r_en0      <= '0;
            r_en1      <= '0;
            r_slot_ptr <= '0;
            r_sel_err  <= 1'b0;
        end else begin
            if (w_push && (bus.dir == 2'b11)) begin
                r_slot_ptr <= w_slot_nxt;
            end
            if (w_push && w_sel_bad) begin
                r_sel_err <= 1'b1;
            end
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_cnt == 2'd0) begin
                        r_dat0 <= w_map_dat;
                        r_en0  <= w_map_en;
                    end else begin
                        r_dat1 <= w_map_dat;
                        r_en1  <= w_map_en;
                    end
                    r_cnt <= r_cnt + 2'd1;
                end
                2'b01: begin
                    r_dat0 <= r_dat1;
                    r_en0  <= r_en1;
                    r_cnt  <= r_cnt - 2'd1;
                end
                2'b11: begin
                    // Only reachable at count 1: the new beat replaces the head.
                    r_dat0 <= w_map_dat;
                    r_en0  <= w_map_en;
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_tb_dina_map_pipe.sv
// ---------------------------------------------------------------------------
// tb_tb_dina_map_pipe
//   Directed bench for tb_dina_map_pipe: an N_SRC=2 instance checked through a
//   scoreboard of mapped beats, and an N_SRC=1 instance for the sel_err path.
// ---------------------------------------------------------------------------
module tb_tb_dina_map_pipe;
    localparam int L  = 4;
    localparam int W  = 32;
    localparam int LW = L * W;

    localparam logic [31:0] LA = 32'hA0A0_0001;
    localparam logic [31:0] LB = 32'hB0B0_0002;
    localparam logic [31:0] LC = 32'hC0C0_0003;
    localparam logic [31:0] LD = 32'hD0D0_0004;

    typedef struct packed {
        logic [LW-1:0] d;
        logic [L-1:0]  en;
    } exp_t;

    logic clk;
    logic sys_rst;
    exp_t q[$];
    int   slot_m;
    int   n_vec;
    int   n_err;

    tb_dina_map_pipe_if #(.L(L), .RSA_DW(W), .N_SRC(2), .SRC_SEL_DW(1), .SLOT_DW(1)) ifa ();
    tb_dina_map_pipe_if #(.L(L), .RSA_DW(W), .N_SRC(1), .SRC_SEL_DW(1), .SLOT_DW(1)) ifb ();

    tb_dina_map_pipe #(.L(L), .RSA_DW(W), .N_SRC(2), .SRC_SEL_DW(1), .NEW_W(2), .SLOT_DW(1))
        u_dut_a (.clk(clk), .sys_rst(sys_rst), .bus(ifa));
    tb_dina_map_pipe #(.L(L), .RSA_DW(W), .N_SRC(1), .SRC_SEL_DW(1), .NEW_W(2), .SLOT_DW(1))
        u_dut_b (.clk(clk), .sys_rst(sys_rst), .bus(ifb));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference mapping for the two-source instance (NEW_W=2, two slots).
    function automatic exp_t model(input logic sel, input logic [1:0] dir,
                                   input int slot, input logic [2*LW-1:0] sd);
        exp_t          e;
        logic [LW-1:0] s;
        e = '0;
        s = sd[int'(sel)*LW +: LW];
        case (dir)
            2'b01: begin
                e.d  = s;
                e.en = 4'hF;
            end
            2'b10: begin
                e.d  = {s[31:0], s[63:32], s[95:64], s[127:96]};
                e.en = 4'hF;
            end
            2'b11: begin
                e.d[slot*64 +: 64] = s[63:0];
                e.en[slot*2 +: 2]  = 2'b11;
            end
            default: e = '0;
        endcase
        return e;
    endfunction

    // One clock: compare/retire at the falling edge, then advance to 1 time unit past the rising edge.
    task automatic tick();
        exp_t e;
        int   k;
        @(negedge clk);
        if (ifa.out_valid === 1'b1 && ifa.out_ready === 1'b1) begin
            n_vec++;
            assert (q.size() != 0) else begin
                n_err++;
                $error("FAIL sb_underflow observed=pop expected=no_pop");
            end
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("sb_dina", ifa.TB_dina, e.d);
                chk("sb_lane_en", LW'(ifa.TB_lane_en), LW'(e.en));
            end
        end
        if (ifa.out_valid === 1'b0) begin
            chk("idle_dina_zero", ifa.TB_dina, '0);
        end
        if (!sys_rst && ifa.in_valid === 1'b1 && ifa.in_ready === 1'b1) begin
            k = ifa.slot_ld ? int'(ifa.slot_in) : slot_m;
            q.push_back(model(ifa.src_sel, ifa.dir, k, ifa.src_data));
            if (ifa.dir == 2'b11) slot_m = (k + 1) % 2;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        slot_m = 0;
        sys_rst = 1'b1;
        ifa.in_valid = 1'b0; ifa.src_sel = '0; ifa.dir = 2'b00; ifa.slot_ld = 1'b0;
        ifa.slot_in = '0; ifa.src_data = '0; ifa.out_ready = 1'b0;
        ifb.in_valid = 1'b0; ifb.src_sel = '0; ifb.dir = 2'b00; ifb.slot_ld = 1'b0;
        ifb.slot_in = '0; ifb.src_data = '0; ifb.out_ready = 1'b0;
        tick();
        tick();

        // Reset state
        chk("rst_in_ready", LW'(ifa.in_ready), LW'(1));
        chk("rst_out_valid", LW'(ifa.out_valid), LW'(0));
        chk("rst_lane_en", LW'(ifa.TB_lane_en), '0);
        chk("rst_sel_err", LW'(ifb.sel_err), LW'(0));
        sys_rst = 1'b0;
        tick();

        // POS then NEG from source 1
        ifa.out_ready = 1'b1;
        ifa.src_data[255:128] = {LD, LC, LB, LA};
        ifa.src_data[127:0]   = {32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444};
        ifa.in_valid = 1'b1; ifa.src_sel = 1'b1; ifa.dir = 2'b01;
        tick();
        chk("pos_dina", ifa.TB_dina, {LD, LC, LB, LA});
        chk("pos_en", LW'(ifa.TB_lane_en), LW'(4'hF));
        ifa.dir = 2'b10;
        tick();
        chk("neg_dina", ifa.TB_dina, {LA, LB, LC, LD});
        chk("neg_en", LW'(ifa.TB_lane_en), LW'(4'hF));

        // NEW with explicit slot 0, then two auto-slot beats
        ifa.src_data[127:0] = {32'hEEEE_EEEE, 32'hFFFF_FFFF, 32'd2, 32'd1};
        ifa.src_sel = 1'b0; ifa.dir = 2'b11; ifa.slot_ld = 1'b1; ifa.slot_in = 1'b0;
        tick();
        chk("new0_dina", ifa.TB_dina, {32'd0, 32'd0, 32'd2, 32'd1});
        chk("new0_en", LW'(ifa.TB_lane_en), LW'(4'h3));
        ifa.slot_ld = 1'b0;
        tick();
        chk("new1_dina", ifa.TB_dina, {32'd2, 32'd1, 32'd0, 32'd0});
        chk("new1_en", LW'(ifa.TB_lane_en), LW'(4'hC));
        tick();
        chk("new2_dina", ifa.TB_dina, {32'd0, 32'd0, 32'd2, 32'd1});
        chk("new2_en", LW'(ifa.TB_lane_en), LW'(4'h3));

        // IDLE bubble; the next NEW beat must still land in slot 1
        ifa.dir = 2'b00;
        tick();
        chk("idle_valid", LW'(ifa.out_valid), LW'(1));
        chk("idle_dina", ifa.TB_dina, '0);
        chk("idle_en", LW'(ifa.TB_lane_en), '0);
        ifa.dir = 2'b11;
        tick();
        chk("new_after_idle_en", LW'(ifa.TB_lane_en), LW'(4'hC));
        ifa.in_valid = 1'b0;
        tick();

        // Backpressure: three POS beats against a stalled sink
        ifa.out_ready = 1'b0;
        ifa.in_valid = 1'b1; ifa.dir = 2'b01;
        ifa.src_data[127:0] = {4{32'h0000_0B01}};
        tick();
        ifa.src_data[127:0] = {4{32'h0000_0B02}};
        tick();
        ifa.src_data[127:0] = {4{32'h0000_0B03}};
        chk("full_in_ready", LW'(ifa.in_ready), LW'(0));
        tick();
        tick();
        chk("stall_head", ifa.TB_dina, {4{32'h0000_0B01}});
        chk("stall_in_ready", LW'(ifa.in_ready), LW'(0));
        ifa.out_ready = 1'b1;
        tick();
        chk("drain_head", ifa.TB_dina, {4{32'h0000_0B02}});
        tick();
        // Count-1 push+pop: beat 3 replaced beat 2 without a bubble
        chk("pushpop_valid", LW'(ifa.out_valid), LW'(1));
        chk("pushpop_head", ifa.TB_dina, {4{32'h0000_0B03}});
        ifa.in_valid = 1'b0;
        tick();
        chk("drained_valid", LW'(ifa.out_valid), LW'(0));
        chk("sb_empty", LW'(q.size()), LW'(0));

        // Out-of-range source on the single-source build
        ifb.out_ready = 1'b1;
        ifb.src_data = {LD, LC, LB, LA};
        ifb.in_valid = 1'b1; ifb.src_sel = 1'b1; ifb.dir = 2'b01;
        tick();
        chk("err_valid", LW'(ifb.out_valid), LW'(1));
        chk("err_dina", ifb.TB_dina, '0);
        chk("err_en", LW'(ifb.TB_lane_en), '0);
        chk("err_flag", LW'(ifb.sel_err), LW'(1));
        ifb.src_sel = 1'b0;
        tick();
        chk("err_ok_dina", ifb.TB_dina, {LD, LC, LB, LA});
        chk("err_sticky", LW'(ifb.sel_err), LW'(1));
        ifb.in_valid = 1'b0;

        // Reset with the FIFO full and slot_ptr at 1
        ifa.out_ready = 1'b0;
        ifa.src_data[127:0] = {32'hEEEE_EEEE, 32'hFFFF_FFFF, 32'd2, 32'd1};
        ifa.in_valid = 1'b1; ifa.dir = 2'b11; ifa.slot_ld = 1'b0;
        tick();
        ifa.dir = 2'b01;
        tick();
        chk("pre_rst_full", LW'(ifa.in_ready), LW'(0));
        sys_rst = 1'b1;
        tick();
        q.delete();
        slot_m = 0;
        chk("mid_rst_valid", LW'(ifa.out_valid), LW'(0));
        chk("mid_rst_ready", LW'(ifa.in_ready), LW'(1));
        chk("mid_rst_sel_err", LW'(ifb.sel_err), LW'(0));
        sys_rst = 1'b0;
        ifa.out_ready = 1'b1;
        ifa.dir = 2'b11;
        tick();
        chk("post_rst_slot0_en", LW'(ifa.TB_lane_en), LW'(4'h3));
        chk("post_rst_slot0_dina", ifa.TB_dina, {32'd0, 32'd0, 32'd2, 32'd1});
        ifa.in_valid = 1'b0;
        tick();
        tick();
        chk("final_sb_empty", LW'(q.size()), LW'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
